// File: rtl/cf_pkg.sv
// cf_pkg: shared constants and FSM state type for the CGB palette file
package cf_pkg;
  localparam logic [15:0] CF_BCPS_ADDR = 16'hFF68;
  localparam logic [15:0] CF_BCPD_ADDR = 16'hFF69;
  localparam logic [15:0] CF_OCPS_ADDR = 16'hFF6A;
  localparam logic [15:0] CF_OCPD_ADDR = 16'hFF6B;
  localparam logic [15:0] CF_INIT_COLOR = 16'h7FFF;
  localparam int AUTOINC = 7;
  localparam int FIXED1 = 6;
  typedef enum logic {INIT, RUN} cf_state_e;
endpackage

// File: rtl/cgb_palette_file_if.sv
// cgb_palette_file_if: CPU register bus and PPU lookup ports of the palette file
interface cgb_palette_file_if #(
  parameter int NUM_PAL = 8,
  parameter int COLORS_PER_PAL = 4
);
  localparam int SEL_W = $clog2(NUM_PAL);
  localparam int CI_W = $clog2(COLORS_PER_PAL);
  logic [15:0] addr;
  logic [7:0] wdata, rdata;
  logic we_l, is_cf_addr, mode3, init_done;
  logic bg_req, bg_valid, spr_req, spr_valid;
  logic [SEL_W-1:0] bg_sel, spr_sel;
  logic [CI_W-1:0] bg_index, spr_index;
  logic [15:0] bg_color, spr_color;
  modport master (
    output addr, wdata, we_l, mode3, bg_req, bg_sel, bg_index, spr_req, spr_sel, spr_index,
    input rdata, is_cf_addr, init_done, bg_valid, bg_color, spr_valid, spr_color
  );
  modport slave (
    input addr, wdata, we_l, mode3, bg_req, bg_sel, bg_index, spr_req, spr_sel, spr_index,
    output rdata, is_cf_addr, init_done, bg_valid, bg_color, spr_valid, spr_color
  );
endinterface

// File: rtl/cf_pal_ram.sv
// cf_pal_ram: byte-wide palette storage with a CPU port and a registered 16-bit colour lookup
module cf_pal_ram #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  input  logic             req,
  input  logic [IDX_W-2:0] entry,
  output logic             valid,
  output logic [15:0]      color
);
  logic [7:0] mem [2**IDX_W];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  // lookup samples pre-write contents, so a same-cycle CPU write is seen one request later
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      color <= '0;
    end else begin
      valid <= req;
      if (req) color <= {mem[{entry, 1'b1}], mem[{entry, 1'b0}]};
    end
endmodule

// File: rtl/cgb_palette_file.sv
// cgb_palette_file: BG/OBJ palette RAMs with spec/data registers, init fill and PPU lookup
module cgb_palette_file
  import cf_pkg::*;
#(
  parameter int NUM_PAL = 8,
  parameter int COLORS_PER_PAL = 4,
  parameter int IDX_W = 6,
  parameter logic [15:0] INIT_COLOR = CF_INIT_COLOR,
  parameter logic [15:0] BCPS_ADDR = CF_BCPS_ADDR,
  parameter logic [15:0] BCPD_ADDR = CF_BCPD_ADDR,
  parameter logic [15:0] OCPS_ADDR = CF_OCPS_ADDR,
  parameter logic [15:0] OCPD_ADDR = CF_OCPD_ADDR
) (
  input logic I_CLK,
  input logic I_RESET,
  cgb_palette_file_if.slave bus
);
  localparam int ENTRY_W = $clog2(NUM_PAL * COLORS_PER_PAL);
  cf_state_e state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic run, commit, prev_we_l;
  logic [15:0] prev_addr;
  logic [1:0] hit_s, hit_d, ai, ram_we;
  logic [1:0][IDX_W-1:0] idx, ram_addr;
  logic [1:0][7:0] ram_rd;
  logic [7:0] wbyte;
  logic [ENTRY_W-1:0] bg_entry, spr_entry;
  assign run = state == RUN;
  assign hit_s = {bus.addr == OCPS_ADDR, bus.addr == BCPS_ADDR};
  assign hit_d = {bus.addr == OCPD_ADDR, bus.addr == BCPD_ADDR};
  assign bus.is_cf_addr = |{hit_s, hit_d};
  assign bus.init_done = run;
  // a held strobe commits only on its first cycle at a given register
  assign commit = run & ~bus.we_l & bus.is_cf_addr & (prev_we_l | prev_addr != bus.addr);
  assign wbyte = run ? bus.wdata : (ptr[0] ? INIT_COLOR[15:8] : INIT_COLOR[7:0]);
  assign ram_we = {2{~run}} | ({2{commit & ~bus.mode3}} & hit_d);
  assign ram_addr = run ? idx : {2{ptr}};
  assign bg_entry = {bus.bg_sel, bus.bg_index};
  assign spr_entry = {bus.spr_sel, bus.spr_index};
  always_comb begin
    state_n = (state == INIT && &ptr) ? RUN : state;
    ptr_n = run ? ptr : ptr + IDX_W'(1);
  end
  always_ff @(posedge I_CLK) begin
    state <= I_RESET ? INIT : state_n;
    ptr <= I_RESET ? '0 : ptr_n;
    prev_we_l <= I_RESET | bus.we_l;
    prev_addr <= bus.addr;
  end
  // data writes advance the index even when the RAM write is locked out by mode 3
  always_ff @(posedge I_CLK)
    for (int c = 0; c < 2; c++)
      if (I_RESET) begin
        ai[c] <= 1'b0;
        idx[c] <= '0;
      end else if (commit & hit_s[c]) begin
        ai[c] <= bus.wdata[AUTOINC];
        idx[c] <= bus.wdata[IDX_W-1:0];
      end else if (commit & hit_d[c] & ai[c]) idx[c] <= idx[c] + IDX_W'(1);
  always_comb begin
    bus.rdata = 8'hFF;
    for (int c = 0; c < 2; c++)
      if (hit_s[c]) begin
        bus.rdata[IDX_W-1:0] = idx[c];
        bus.rdata[FIXED1] = 1'b1;
        bus.rdata[AUTOINC] = ai[c];
      end else if (hit_d[c] & run & ~bus.mode3) bus.rdata = ram_rd[c];
  end
  cf_pal_ram #(.IDX_W(IDX_W)) u_bg (
    .clk(I_CLK), .rst(I_RESET), .we(ram_we[0]), .addr(ram_addr[0]), .wdata(wbyte),
    .rdata(ram_rd[0]), .req(bus.bg_req & run), .entry(bg_entry),
    .valid(bus.bg_valid), .color(bus.bg_color)
  );
  cf_pal_ram #(.IDX_W(IDX_W)) u_spr (
    .clk(I_CLK), .rst(I_RESET), .we(ram_we[1]), .addr(ram_addr[1]), .wdata(wbyte),
    .rdata(ram_rd[1]), .req(bus.spr_req & run), .entry(spr_entry),
    .valid(bus.spr_valid), .color(bus.spr_color)
  );
endmodule

// File: tb/tb_cgb_palette_file.sv
// tb_cgb_palette_file: directed and random checks of cgb_palette_file against a behavioural palette model
module tb_cgb_palette_file;
  localparam logic [15:0] BCPS = 16'hFF68, BCPD = 16'hFF69, OCPS = 16'hFF6A, OCPD = 16'hFF6B;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cgb_palette_file_if bus ();
  cgb_palette_file dut (.I_CLK(clk), .I_RESET(rst), .bus(bus));

  int total = 0, passed = 0;
  bit chk_en = 0;
  logic [7:0] m_mem [2][64];
  bit m_ai [2];
  int m_idx [2];
  int m_cnt = 0;
  bit m_valid [2];
  logic [15:0] m_color [2];
  bit m_pwe = 1, m_run;
  logic [15:0] m_paddr;
  bit req [2];
  int ent [2];

  task automatic cmp(string n, logic [15:0] a, logic [15:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: dut=%h expected=%h at %0t", n, a, e, $time);
  endtask

  function automatic bit is_cf(logic [15:0] a);
    return a >= BCPS && a <= OCPD;
  endfunction

  function automatic logic [7:0] exp_rd();
    for (int c = 0; c < 2; c++) begin
      if (bus.addr == BCPS + 16'(2 * c)) return (m_ai[c] ? 8'hC0 : 8'h40) | 8'(m_idx[c]);
      if (bus.addr == BCPD + 16'(2 * c)) return (m_cnt < 64 || bus.mode3) ? 8'hFF : m_mem[c][m_idx[c]];
    end
    return 8'hFF;
  endfunction

  // palette behaviour: 64 init cycles, then first-cycle-of-strobe commits and 1-cycle lookups
  task automatic model_step();
    if (rst) begin
      m_cnt = 0;
      for (int c = 0; c < 2; c++) begin
        m_ai[c] = 0; m_idx[c] = 0; m_valid[c] = 0; m_color[c] = 16'h0000;
      end
    end else begin
      m_run = m_cnt >= 64;
      req[0] = bus.bg_req; req[1] = bus.spr_req;
      ent[0] = int'(bus.bg_sel) * 4 + int'(bus.bg_index);
      ent[1] = int'(bus.spr_sel) * 4 + int'(bus.spr_index);
      for (int c = 0; c < 2; c++) begin
        m_valid[c] = m_run && req[c];
        if (m_valid[c]) m_color[c] = {m_mem[c][2 * ent[c] + 1], m_mem[c][2 * ent[c]]};
      end
      if (!m_run) begin
        for (int c = 0; c < 2; c++) m_mem[c][m_cnt] = (m_cnt % 2) ? 8'h7F : 8'hFF;
        m_cnt++;
      end else if (!bus.we_l && is_cf(bus.addr) && (m_pwe || m_paddr != bus.addr)) begin
        for (int c = 0; c < 2; c++) begin
          if (bus.addr == BCPS + 16'(2 * c)) begin
            m_ai[c] = bus.wdata[7];
            m_idx[c] = int'(bus.wdata[5:0]);
          end
          if (bus.addr == BCPD + 16'(2 * c)) begin
            if (!bus.mode3) m_mem[c][m_idx[c]] = bus.wdata;
            if (m_ai[c]) m_idx[c] = (m_idx[c] + 1) % 64;
          end
        end
      end
    end
    m_pwe = rst || bus.we_l;
    m_paddr = bus.addr;
  endtask

  task automatic compare();
    cmp("init_done", 16'(bus.init_done), 16'(m_cnt >= 64));
    cmp("is_cf_addr", 16'(bus.is_cf_addr), 16'(is_cf(bus.addr)));
    cmp("rdata", 16'(bus.rdata), 16'(exp_rd()));
    cmp("bg_valid", 16'(bus.bg_valid), 16'(m_valid[0]));
    cmp("bg_color", bus.bg_color, m_color[0]);
    cmp("spr_valid", 16'(bus.spr_valid), 16'(m_valid[1]));
    cmp("spr_color", bus.spr_color, m_color[1]);
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) if (chk_en) compare();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] d);
    step();
    bus.addr = a; bus.wdata = d; bus.we_l = 1'b0;
    step();
    bus.we_l = 1'b1;
  endtask

  task automatic read_chk(logic [15:0] a, string n, logic [7:0] e);
    step();
    bus.addr = a; bus.we_l = 1'b1;
    @(negedge clk);
    cmp(n, 16'(bus.rdata), 16'(e));
  endtask

  task automatic ppu_chk(bit ch, logic [2:0] sel, logic [1:0] ix, logic [15:0] e, string n);
    step();
    if (ch) begin bus.spr_req = 1; bus.spr_sel = sel; bus.spr_index = ix; end
    else begin bus.bg_req = 1; bus.bg_sel = sel; bus.bg_index = ix; end
    step();
    bus.bg_req = 0; bus.spr_req = 0;
    @(negedge clk);
    cmp({n, "_valid"}, 16'(ch ? bus.spr_valid : bus.bg_valid), 16'h1);
    cmp({n, "_color"}, ch ? bus.spr_color : bus.bg_color, e);
  endtask

  // counts edges after reset release until init_done, striking the CPU bus while waiting
  task automatic wait_init(output int n, input bit poke);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      bus.addr = BCPS; bus.wdata = 8'hBE;
      bus.we_l = !(poke && n % 2 == 1 && n < 60);
    end while (!bus.init_done && n < 200);
    bus.we_l = 1'b1;
  endtask

  initial begin
    int n;
    bus.addr = 16'h0000; bus.wdata = 8'h00; bus.we_l = 1'b1; bus.mode3 = 1'b0;
    bus.bg_req = 0; bus.bg_sel = 0; bus.bg_index = 0;
    bus.spr_req = 0; bus.spr_sel = 0; bus.spr_index = 0;
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_init(n, 0);
    cmp("init_cycles", 16'(n), 16'd64);
    ppu_chk(0, 3'd3, 2'd2, 16'h7FFF, "bg_after_init");
    read_chk(BCPS, "bcps_reset", 8'h40);

    wr(BCPS, 8'hBE); wr(BCPD, 8'h1F); wr(BCPD, 8'h00); wr(BCPD, 8'hAA);
    read_chk(BCPS, "bcps_wrapped", 8'hC1);
    read_chk(OCPS, "ocps_untouched", 8'h40);
    wr(BCPS, 8'h3E); read_chk(BCPD, "ram62", 8'h1F);
    wr(BCPS, 8'h3F); read_chk(BCPD, "ram63", 8'h00);
    wr(BCPS, 8'h00); read_chk(BCPD, "ram0", 8'hAA);

    wr(BCPS, 8'h84);
    step();
    bus.addr = BCPD; bus.wdata = 8'h77; bus.we_l = 1'b0;
    repeat (5) step();
    bus.we_l = 1'b1;
    read_chk(BCPS, "held_strobe_idx", 8'hC5);
    wr(BCPS, 8'h04); read_chk(BCPD, "held_strobe_ram4", 8'h77);
    wr(BCPS, 8'h05); read_chk(BCPD, "held_strobe_ram5", 8'h7F);

    wr(OCPS, 8'h84);
    step();
    bus.mode3 = 1'b1;
    wr(OCPD, 8'h12);
    read_chk(OCPS, "mode3_ocps", 8'hC5);
    read_chk(OCPD, "mode3_ocpd", 8'hFF);
    step();
    bus.mode3 = 1'b0;
    ppu_chk(1, 3'd0, 2'd2, 16'h7FFF, "mode3_ram_kept");

    wr(BCPS, 8'h00);
    step();
    bus.addr = BCPD; bus.wdata = 8'h55; bus.we_l = 1'b0;
    bus.bg_req = 1; bus.bg_sel = 0; bus.bg_index = 0;
    step();
    bus.we_l = 1'b1;
    @(negedge clk);
    cmp("same_cycle_old", bus.bg_color, 16'h7FAA);
    step();
    bus.bg_req = 0;
    @(negedge clk);
    cmp("next_cycle_new", bus.bg_color, 16'h7F55);

    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_init(n, 1);
    cmp("reinit_cycles", 16'(n), 16'd64);
    read_chk(BCPS, "reinit_bcps", 8'h40);
    read_chk(BCPD, "reinit_ram0", 8'hFF);

    for (int i = 0; i < 3000; i++) begin
      step();
      rst = (i >= 1500 && i < 1502);
      bus.addr = ($urandom_range(0, 4) == 4) ? 16'($urandom) : BCPS + 16'($urandom_range(0, 3));
      bus.we_l = 1'($urandom);
      bus.wdata = 8'($urandom);
      bus.mode3 = ($urandom_range(0, 3) == 0);
      bus.bg_req = 1'($urandom); bus.bg_sel = 3'($urandom); bus.bg_index = 2'($urandom);
      bus.spr_req = 1'($urandom); bus.spr_sel = 3'($urandom); bus.spr_index = 2'($urandom);
    end
    step();
    rst = 1'b0; bus.we_l = 1'b1; bus.bg_req = 0; bus.spr_req = 0;
    repeat (3) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
